// File: rtl/buffer_ram_mrw_bypass.sv
// -----------------------------------------------------------------------------
// buffer_ram_mrw_bypass
//   One write port and NUM_RD independent, fully pipelined read ports over a
//   single logical array. The array sits behind a one-cycle write stage.
//   Optional forwarding makes reads see same-cycle and staged writes.
//   An optional clear sequencer zeroes the array after every reset.
//
// Ports
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   wren      : write request (accepted only once init_done is high)
//   waddr     : write address; addresses >= DEPTH are dropped
//   wdata     : write data
//   ren       : per-port read request
//   raddr     : packed read addresses, port i at [i*DEPTHAD +: DEPTHAD]
//   rdata     : packed read data, port i at [i*WIDTH +: WIDTH], 0 when invalid
//   rvalid    : per-port read valid, READ_LATENCY cycles after ren
//   init_done : array ready for traffic
// -----------------------------------------------------------------------------
module buffer_ram_mrw_bypass #(
  parameter int WIDTH          = 16,  // legacy FSIZE word width
  parameter int DEPTH          = 512, // need not be a power of two (DEPTH >= 2)
  parameter int NUM_RD         = 4,
  parameter int READ_LATENCY   = 2,   // legacy BUFFER_READ_LATENCY, >= 1
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DEPTHAD        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wren,
  input  logic [DEPTHAD-1:0]        waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [NUM_RD-1:0]         ren,
  input  logic [NUM_RD*DEPTHAD-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]         rvalid,
  output logic                      init_done
);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t             state_reg;
  logic [DEPTHAD-1:0] clr_cnt_reg;
  logic               init_done_reg;
  logic               ready;

  assign ready     = (state_reg == ST_READY);
  assign init_done = init_done_reg;

  // Post-reset sequencer: RESET -> CLEAR (one address per cycle) -> READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_RESET;
      clr_cnt_reg   <= '0;
      init_done_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_RESET: begin
          clr_cnt_reg <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state_reg <= ST_CLEAR;
          end else begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (32'(clr_cnt_reg) == DEPTH - 1) begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + DEPTHAD'(1);
          end
        end
        ST_READY: begin
          state_reg <= ST_READY;
        end
        default: begin
          state_reg <= ST_RESET;
        end
      endcase
    end
  end

  // Write stage: only in-range writes accepted in READY are ever staged, so
  // a staged entry is always safe to forward and to commit.
  logic               wr_accept;
  logic               wstage_valid_reg;
  logic [DEPTHAD-1:0] wstage_addr_reg;
  logic [WIDTH-1:0]   wstage_data_reg;

  assign wr_accept = ready && wren && (32'(waddr) < DEPTH);

  always_ff @(posedge clk) begin
    wstage_addr_reg <= waddr;
    wstage_data_reg <= wdata;
    if (!rst_n) begin
      wstage_valid_reg <= 1'b0;
    end else begin
      wstage_valid_reg <= wr_accept;
    end
  end

  // Single physical write port shared by the clear sequencer and the write
  // stage. Nothing commits on a reset cycle, which discards a staged write.
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               mem_we;
  logic [DEPTHAD-1:0] mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wstage_addr_reg;
    mem_wdata = wstage_data_reg;
    if (rst_n) begin
      if (state_reg == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_reg;
        mem_wdata = '0;
      end else if (wstage_valid_reg) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DEPTHAD-1:0] addr;
      logic               in_range;
      logic [DEPTHAD-1:0] mem_idx;
      logic               hit_now;
      logic               hit_stage;
      logic               s0_valid_reg;
      logic               s0_oor_reg;
      logic               s0_fwd_reg;
      logic [WIDTH-1:0]   s0_fwd_data_reg;
      logic [WIDTH-1:0]   s0_mem_reg;
      logic [WIDTH-1:0]   s0_data;
      logic               out_v;
      logic [WIDTH-1:0]   out_d;

      assign addr     = raddr[gi*DEPTHAD +: DEPTHAD];
      assign in_range = (32'(addr) < DEPTH);
      // Keep the array index legal; the out-of-range flag zeroes the result.
      assign mem_idx  = in_range ? addr : '0;

      // The array read is read-before-write, so a write committing on the
      // same edge is only visible through forwarding. The same-cycle write
      // is newer than the staged one and therefore wins.
      assign hit_now   = (BYPASS != 0) && wr_accept && (waddr == addr);
      assign hit_stage = (BYPASS != 0) && wstage_valid_reg && (wstage_addr_reg == addr);

      always_ff @(posedge clk) begin
        s0_mem_reg      <= mem[mem_idx];
        s0_oor_reg      <= !in_range;
        s0_fwd_reg      <= hit_now || hit_stage;
        s0_fwd_data_reg <= hit_now ? wdata : wstage_data_reg;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s0_valid_reg <= 1'b0;
        end else begin
          s0_valid_reg <= ready && ren[gi];
        end
      end

      assign s0_data = s0_oor_reg ? '0 : (s0_fwd_reg ? s0_fwd_data_reg : s0_mem_reg);

      if (READ_LATENCY > 1) begin : g_pipe
        logic [READ_LATENCY-2:0] v_reg;
        logic [WIDTH-1:0]        d_reg [READ_LATENCY-1];

        always_ff @(posedge clk) begin
          d_reg[0] <= s0_data;
          for (int k = 1; k < READ_LATENCY - 1; k++) begin
            d_reg[k] <= d_reg[k-1];
          end
          if (!rst_n) begin
            v_reg <= '0;
          end else begin
            v_reg[0] <= s0_valid_reg;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
              v_reg[k] <= v_reg[k-1];
            end
          end
        end

        assign out_v = v_reg[READ_LATENCY-2];
        assign out_d = d_reg[READ_LATENCY-2];
      end else begin : g_nopipe
        assign out_v = s0_valid_reg;
        assign out_d = s0_data;
      end

      assign rvalid[gi]                = out_v;
      assign rdata[gi*WIDTH +: WIDTH]  = out_v ? out_d : '0;
    end
  endgenerate

endmodule

// File: tb/tb_buffer_ram_mrw_bypass.sv
module tb_buffer_ram_mrw_bypass;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 12;
  localparam int NUM_RD = 4;
  localparam int RL     = 3;
  localparam int AW     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   wren;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [NUM_RD-1:0]      ren;
  logic [NUM_RD*AW-1:0]   raddr;
  logic [NUM_RD*WIDTH-1:0] rdata_a, rdata_b;
  logic [NUM_RD-1:0]      rvalid_a, rvalid_b;
  logic                   init_done_a, init_done_b;

  // Instance a forwards writes to reads, instance b does not.
  buffer_ram_mrw_bypass #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .READ_LATENCY(RL),
    .BYPASS(1), .CLEAR_ON_RESET(1), .DEPTHAD(AW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wren(wren), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
    .init_done(init_done_a)
  );

  buffer_ram_mrw_bypass #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .READ_LATENCY(RL),
    .BYPASS(0), .CLEAR_ON_RESET(1), .DEPTHAD(AW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wren(wren), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
    .init_done(init_done_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;
  int ready_from   = 1 << 30;

  // Reference model: log of accepted writes stamped with the edge that
  // sampled them. A read sampled at edge e sees the newest logged write to
  // its address with stamp <= e (forwarding) or <= e-2 (no forwarding);
  // with no such write the cleared value 0 applies.
  typedef struct {
    int         e;
    int         a;
    logic [7:0] d;
  } wr_t;
  wr_t wlog[$];

  task automatic tick();
    wr_t w;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      wlog.delete();
      ready_from = edge_n + DEPTH + 2;
    end else if (wren && edge_n >= ready_from && int'(waddr) < DEPTH) begin
      w.e = edge_n;
      w.a = int'(waddr);
      w.d = wdata;
      wlog.push_back(w);
    end
    #1;
  endtask

  function automatic logic [7:0] model_rd(int e, int a, bit byp);
    int lim;
    lim = byp ? e : e - 2;
    if (a >= DEPTH) return 8'h00;
    for (int i = wlog.size() - 1; i >= 0; i--) begin
      if (wlog[i].a == a && wlog[i].e <= lim) return wlog[i].d;
    end
    return 8'h00;
  endfunction

  task automatic set_raddr(int p, int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle(int n);
    wren = 1'b0;
    ren  = '0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wren = 1'b0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
    repeat (3) tick();
    tests_run++;
    if ({rvalid_a, rvalid_b} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_rvalid: got a=%b b=%b expected 0", rvalid_a, rvalid_b);
    end
    tests_run++;
    if ({rdata_a, rdata_b} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got a=%h b=%h expected 0", rdata_a, rdata_b);
    end
    tests_run++;
    if ({init_done_a, init_done_b} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_init_done: got a=%b b=%b expected 0", init_done_a, init_done_b);
    end
  endtask

  task automatic test_clear();
    logic exp;
    rst_n = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      exp = (k == DEPTH + 1);
      tests_run++;
      if ({init_done_a, init_done_b} !== {exp, exp}) begin
        tests_failed++;
        $display("FAIL clear_init_done cycle %0d: got a=%b b=%b expected %b",
                 k, init_done_a, init_done_b, exp);
      end
    end
    // Stream reads of every address on port 0, one per cycle.
    for (int k = 0; k < DEPTH + 2; k++) begin
      ren = (k < DEPTH) ? 4'b0001 : 4'b0000;
      set_raddr(0, (k < DEPTH) ? k : 0);
      tick();
      if (k >= 2) begin
        tests_run++;
        if (rvalid_a[0] !== 1'b1 || rvalid_b[0] !== 1'b1 ||
            rdata_a[7:0] !== 8'h00 || rdata_b[7:0] !== 8'h00) begin
          tests_failed++;
          $display("FAIL clear_read addr %0d: got v=%b/%b d=%h/%h expected v=1 d=00",
                   k - 2, rvalid_a[0], rvalid_b[0], rdata_a[7:0], rdata_b[7:0]);
        end
      end
    end
    ren = '0;
  endtask

  task automatic test_multiport();
    wren = 1'b1; waddr = 4'd3; wdata = 8'hA5; tick();
    waddr = 4'd7; wdata = 8'h5A; tick();
    idle(2);
    ren   = 4'b1111;
    raddr = {4'd3, 4'd7, 4'd3, 4'd7};
    tick();
    ren = '0;
    tick();
    tests_run++;
    if ({rvalid_a, rvalid_b} !== 8'h00) begin
      tests_failed++;
      $display("FAIL multiport_early: got a=%b b=%b expected 0 one cycle early", rvalid_a, rvalid_b);
    end
    tick();
    tests_run++;
    if (rvalid_a !== 4'b1111 || rvalid_b !== 4'b1111) begin
      tests_failed++;
      $display("FAIL multiport_rvalid: got a=%b b=%b expected 1111", rvalid_a, rvalid_b);
    end
    tests_run++;
    if (rdata_a !== 32'hA55AA55A || rdata_b !== 32'hA55AA55A) begin
      tests_failed++;
      $display("FAIL multiport_rdata: got a=%h b=%h expected a55aa55a", rdata_a, rdata_b);
    end
    tick();
    tests_run++;
    if ({rvalid_a, rvalid_b} !== 8'h00) begin
      tests_failed++;
      $display("FAIL multiport_pulse: got a=%b b=%b expected 0 after one cycle", rvalid_a, rvalid_b);
    end
  endtask

  task automatic test_bypass();
    logic [7:0]  ea [3];
    logic [7:0]  eb [3];
    logic [3:0]  mask [3];
    logic [31:0] pa, pb;
    ea   = '{8'h22, 8'h22, 8'h22};
    eb   = '{8'h11, 8'h11, 8'h22};
    mask = '{4'b1111, 4'b0001, 4'b0001};
    wren = 1'b1; waddr = 4'd5; wdata = 8'h11; tick();
    idle(2);
    for (int j = 0; j < 5; j++) begin
      wren  = (j == 0);
      waddr = 4'd5;
      wdata = 8'h22;
      ren   = (j == 0) ? 4'b1111 : ((j < 3) ? 4'b0001 : 4'b0000);
      raddr = {4'd5, 4'd5, 4'd5, 4'd5};
      tick();
      if (j >= 2) begin
        pa = '0;
        pb = '0;
        for (int p = 0; p < NUM_RD; p++) begin
          if (mask[j-2][p]) begin
            pa[p*8 +: 8] = ea[j-2];
            pb[p*8 +: 8] = eb[j-2];
          end
        end
        tests_run++;
        if (rvalid_a !== mask[j-2] || rdata_a !== pa) begin
          tests_failed++;
          $display("FAIL bypass_on read t+%0d: got v=%b d=%h expected v=%b d=%h",
                   j - 2, rvalid_a, rdata_a, mask[j-2], pa);
        end
        tests_run++;
        if (rvalid_b !== mask[j-2] || rdata_b !== pb) begin
          tests_failed++;
          $display("FAIL bypass_off read t+%0d: got v=%b d=%h expected v=%b d=%h",
                   j - 2, rvalid_b, rdata_b, mask[j-2], pb);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_out_of_range();
    wren = 1'b1; waddr = 4'd1; wdata = 8'h3C; tick();
    idle(2);
    // Same-cycle out-of-range write and read must not forward.
    wren = 1'b1; waddr = 4'd13; wdata = 8'hFF;
    ren = 4'b0011; set_raddr(0, 13); set_raddr(1, 1);
    tick();
    wren = 1'b0;
    ren = 4'b1100; set_raddr(2, 13); set_raddr(3, 1);
    tick();
    ren = '0;
    tick();
    tests_run++;
    if (rvalid_a !== 4'b0011 || rvalid_b !== 4'b0011 ||
        rdata_a !== 32'h00003C00 || rdata_b !== 32'h00003C00) begin
      tests_failed++;
      $display("FAIL oor_same_cycle: got v=%b/%b d=%h/%h expected v=0011 d=00003c00",
               rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
    tick();
    tests_run++;
    if (rvalid_a !== 4'b1100 || rvalid_b !== 4'b1100 ||
        rdata_a !== 32'h3C000000 || rdata_b !== 32'h3C000000) begin
      tests_failed++;
      $display("FAIL oor_after_write: got v=%b/%b d=%h/%h expected v=1100 d=3c000000",
               rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
    idle(1);
  endtask

  task automatic test_random();
    localparam int N = 200;
    logic [3:0]  ring_v [4];
    logic [31:0] ring_a [4];
    logic [31:0] ring_b [4];
    int          ra [NUM_RD];
    int          slot;
    for (int i = 0; i < 4; i++) begin
      ring_v[i] = '0; ring_a[i] = '0; ring_b[i] = '0;
    end
    for (int i = 0; i < N + 2; i++) begin
      if (i < N) begin
        wren  = 1'($urandom_range(0, 1));
        waddr = AW'($urandom_range(0, 15));
        wdata = WIDTH'($urandom);
        ren   = NUM_RD'($urandom);
        for (int p = 0; p < NUM_RD; p++) begin
          ra[p] = int'($urandom_range(0, 13));
          set_raddr(p, ra[p]);
        end
      end else begin
        wren = 1'b0;
        ren  = '0;
      end
      tick();
      slot = edge_n % 4;
      ring_v[slot] = ren;
      ring_a[slot] = '0;
      ring_b[slot] = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        if (ren[p]) begin
          ring_a[slot][p*8 +: 8] = model_rd(edge_n, ra[p], 1'b1);
          ring_b[slot][p*8 +: 8] = model_rd(edge_n, ra[p], 1'b0);
        end
      end
      slot = (edge_n - (RL - 1)) % 4;
      tests_run++;
      if (rvalid_a !== ring_v[slot] || rdata_a !== ring_a[slot]) begin
        tests_failed++;
        $display("FAIL random_bypass_on edge %0d: got v=%b d=%h expected v=%b d=%h",
                 edge_n, rvalid_a, rdata_a, ring_v[slot], ring_a[slot]);
      end
      tests_run++;
      if (rvalid_b !== ring_v[slot] || rdata_b !== ring_b[slot]) begin
        tests_failed++;
        $display("FAIL random_bypass_off edge %0d: got v=%b d=%h expected v=%b d=%h",
                 edge_n, rvalid_b, rdata_b, ring_v[slot], ring_b[slot]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    ren = 4'b1111;
    for (int p = 0; p < NUM_RD; p++) set_raddr(p, int'($urandom_range(0, DEPTH - 1)));
    wren = 1'b1; waddr = 4'd9; wdata = 8'hEE;
    tick();
    wren = 1'b0; ren = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if ({rvalid_a, rvalid_b} !== 8'h00 || {init_done_a, init_done_b} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midflight_t2: got v=%b/%b init=%b/%b expected all 0",
               rvalid_a, rvalid_b, init_done_a, init_done_b);
    end
    tick();
    tests_run++;
    if ({rvalid_a, rvalid_b} !== 8'h00) begin
      tests_failed++;
      $display("FAIL midflight_t3: got v=%b/%b expected 0", rvalid_a, rvalid_b);
    end
  endtask

  task automatic test_gating();
    logic exp_init;
    while (edge_n + 1 < ready_from) begin
      wren = 1'b1; waddr = 4'd2; wdata = 8'h77;
      ren = 4'b0010; set_raddr(1, 2);
      tick();
      exp_init = (edge_n >= ready_from - 1);
      tests_run++;
      if ({rvalid_a, rvalid_b} !== 8'h00 || {init_done_a, init_done_b} !== {exp_init, exp_init}) begin
        tests_failed++;
        $display("FAIL gating_clear edge %0d: got v=%b/%b init=%b/%b expected v=0 init=%b",
                 edge_n, rvalid_a, rvalid_b, init_done_a, init_done_b, exp_init);
      end
    end
    for (int k = 0; k < 2; k++) begin
      idle(1);
      tests_run++;
      if ({rvalid_a, rvalid_b} !== 8'h00) begin
        tests_failed++;
        $display("FAIL gating_tail %0d: got v=%b/%b expected 0", k, rvalid_a, rvalid_b);
      end
    end
    ren = 4'b0011; set_raddr(0, 9); set_raddr(1, 2);
    tick();
    idle(2);
    tests_run++;
    if (rvalid_a !== 4'b0011 || rvalid_b !== 4'b0011 ||
        rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
      tests_failed++;
      $display("FAIL gating_readback: got v=%b/%b d=%h/%h expected v=0011 d=0",
               rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_multiport();
    test_bypass();
    test_out_of_range();
    test_random();
    test_reset_midflight();
    test_gating();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
